// File: rtl/hls_target_div_pkg.sv
// hls_target_div_pkg: shared widths and FSM states for the sequential divider
package hls_target_div_pkg;
  localparam int DIVIDEND_W = 21;
  localparam int DIVISOR_W  = 8;
  localparam int QUOTIENT_W = 13;
  localparam int CNT_W      = $clog2(DIVIDEND_W);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/hls_target_udiv_step.sv
// hls_target_udiv_step: one combinational restoring-division iteration
module hls_target_udiv_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   partial,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   rem_next,
  output logic          q_bit
);
  logic [DW+1:0] wide;
  // shift in the next dividend bit; subtract when the divisor fits
  always_comb begin
    wide     = {partial, bit_in};
    q_bit    = wide >= {2'b00, divisor};
    rem_next = (DW+1)'(q_bit ? wide - {2'b00, divisor} : wide);
  end
endmodule

// File: rtl/hls_target_udiv_21ns_8ns_13_seq.sv
// hls_target_udiv_21ns_8ns_13_seq: sequential restoring divider with saturating quotient
module hls_target_udiv_21ns_8ns_13_seq
  import hls_target_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W,
  parameter int QUOTIENT_WIDTH = QUOTIENT_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [QUOTIENT_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      ovf,
  output logic                      dbz
);
  localparam int CW = $clog2(DIVIDEND_WIDTH);
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] dividend_q, dividend_d;
  logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d;
  logic [DIVISOR_WIDTH:0]    partial_q, partial_d;
  logic [DIVIDEND_WIDTH-1:0] quotient_q, quotient_d;
  logic [QUOTIENT_WIDTH-1:0] quot_q, quot_d;
  logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
  logic                      ovf_q, ovf_d, dbz_q, dbz_d;
  logic [DIVISOR_WIDTH:0]    rem_next;
  logic                      q_bit;
  logic [DIVIDEND_WIDTH-1:0] q_next;
  logic                      last, hi_nz, zero_div;
  hls_target_udiv_step #(.DW(DIVISOR_WIDTH)) u_step (
    .partial  (partial_q),
    .bit_in   (dividend_q[DIVIDEND_WIDTH-1]),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );
  // next-state, datapath and result-register loading
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    partial_d  = partial_q;
    quotient_d = quotient_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;
    q_next     = (quotient_q << 1) | DIVIDEND_WIDTH'(q_bit);
    last       = cnt_q == CW'(DIVIDEND_WIDTH - 1);
    hi_nz      = |q_next[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH];
    zero_div   = divisor_q == '0;
    case (state_q)
      IDLE: if (din_valid) begin
        state_d    = CALC;
        dividend_d = din0;
        divisor_d  = din1;
        partial_d  = '0;
        quotient_d = '0;
        cnt_d      = '0;
      end
      CALC: begin
        partial_d  = rem_next;
        dividend_d = dividend_q << 1;
        quotient_d = q_next;
        cnt_d      = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          dbz_d   = zero_div;
          ovf_d   = !zero_div && hi_nz;
          quot_d  = (zero_div || hi_nz) ? '1 : q_next[QUOTIENT_WIDTH-1:0];
          rem_d   = zero_div ? '0 : rem_next[DIVISOR_WIDTH-1:0];
        end
      end
      DONE: if (dout_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset discards any in-flight operation
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      partial_q  <= '0;
      quotient_q <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      partial_q  <= partial_d;
      quotient_q <= quotient_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
    end
  end
  assign din_ready  = state_q == IDLE;
  assign dout_valid = state_q == DONE;
  assign quot       = quot_q;
  assign rem        = rem_q;
  assign ovf        = ovf_q;
  assign dbz        = dbz_q;
endmodule

// File: doc/hls_target_udiv_21ns_8ns_13_seq.md
# hls_target_udiv_21ns_8ns_13_seq

Sequential unsigned divider, the inverse of the 13×8→21 product path in the Gaussian HLS datapath. Recovers a 13-bit quotient and 8-bit remainder from a 21-bit dividend and an 8-bit divisor, e.g. when normalising accumulated kernel sums. Restoring algorithm, one quotient bit per cycle. Valid/ready handshake on both sides, single transaction in flight.

## Interface
- DIVIDEND_WIDTH, 21, dividend width; also the number of iterations.
- DIVISOR_WIDTH, 8, divisor and remainder width.
- QUOTIENT_WIDTH, 13, output quotient width; wider results saturate.
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- din_valid  in  1  operands valid.
- din_ready  out  1  block can accept operands.
- din0  in  DIVIDEND_WIDTH  unsigned dividend.
- din1  in  DIVISOR_WIDTH  unsigned divisor.
- dout_valid  out  1  result valid.
- dout_ready  in  1  consumer accepts result.
- quot  out  QUOTIENT_WIDTH  quotient, saturated.
- rem  out  DIVISOR_WIDTH  remainder.
- ovf  out  1  true quotient exceeded 2^QUOTIENT_WIDTH−1.
- dbz  out  1  divisor was zero.

## Operation
- **States and transitions:**
  - IDLE → CALC on din_valid & din_ready.
  - CALC → DONE after DIVIDEND_WIDTH iterations.
  - DONE → IDLE on dout_valid & dout_ready.
- **Handshake flags:** din_ready = (state == IDLE). dout_valid = (state == DONE).
- **On accept:**
  - Latch din0 into the dividend shift register and din1 into the divisor register.
  - Clear the partial remainder (DIVISOR_WIDTH+1 bits), the DIVIDEND_WIDTH-bit quotient accumulator and the iteration counter.
- **Each CALC cycle:**
  - Shift the partial remainder left by one, taking in the dividend MSB; shift the dividend left.
  - If partial ≥ divisor, subtract the divisor and shift 1 into the quotient; otherwise shift 0.
  - The counter runs 0..DIVIDEND_WIDTH−1. The CALC edge at count DIVIDEND_WIDTH−1 moves to DONE.
- **Output registers, loaded on the CALC→DONE edge:**
  - If the divisor is 0: quot = all ones, rem = 0, dbz = 1, ovf = 0.
  - Else, if quotient bits [DIVIDEND_WIDTH−1:QUOTIENT_WIDTH] are not all zero: quot = all ones, ovf = 1.
  - Else: quot = quotient[QUOTIENT_WIDTH−1:0], ovf = 0.
  - In the non-zero-divisor cases rem = the partial remainder [DIVISOR_WIDTH−1:0] and dbz = 0.
- Output registers hold their values from DONE until the next CALC→DONE edge. They are not cleared on the DONE→IDLE handshake.
- din0/din1 are ignored outside the accept cycle. dout_ready is ignored outside DONE.
- **Reset (any state, including mid-CALC):**
  - Returns immediately to IDLE.
  - din_ready = 1, dout_valid = 0, quot = 0, rem = 0, ovf = 0, dbz = 0.
  - The in-flight operation is discarded and produces no output.

## Timing
- Accept in cycle T. CALC occupies T+1..T+DIVIDEND_WIDTH. dout_valid is first high in cycle T+DIVIDEND_WIDTH+1 (T+22 at defaults).
- Result handshake in cycle D puts the block in IDLE in D+1, with din_ready = 1 in D+1. Minimum spacing between accepts is DIVIDEND_WIDTH+2 cycles (23).
- Latency is fixed and data-independent, including the divide-by-zero case.
- Backpressure: while dout_ready = 0 in DONE, quot/rem/ovf/dbz are held stable and din_ready stays 0.
- All outputs are registered or decoded from the state register. There is no combinational path from din_* or dout_ready to any output.

## Structure
- **Shared package hls_target_div_pkg:**
  - Width constants (21/8/13).
  - Counter width, $clog2(DIVIDEND_WIDTH).
  - State enum: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
- **Sub-module hls_target_udiv_step:**
  - Combinational single restoring iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder and the quotient bit.
  - Instantiated once; the top level holds the FSM, counter and registers.

## Test plan
- Divide 1000003 by 200 → quot 5000, rem 3, ovf 0, dbz 0. dout_valid is first high exactly 22 cycles after the accept cycle.
- Divide 2088959 by 255 → quot 8191, rem 254, ovf 0 (largest non-saturating case).
- Divide 2097151 by 255 → true quotient 8224 remainder 31. Required: quot 8191, rem 31, ovf 1.
- Divide 12345 by 0 → quot 8191, rem 0, dbz 1, ovf 0, same 22-cycle latency.
- Backpressure: 1000000 by 200 with dout_ready held low 5 cycles in DONE.
  - quot 5000 / rem 0 stay stable and din_ready stays 0 throughout.
  - Raising dout_ready gives din_ready = 1 on the next cycle.
  - A new operation offered during the stall is accepted only after that.
- Reset mid-operation: assert ap_rst_n low at CALC iteration 10.
  - Required: immediately dout_valid 0, din_ready 1, quot/rem 0.
  - After release, 500 by 7 → quot 71, rem 3, and no stale result appears.
